// File: rtl/modulator_symbol_sequencer_pkg.sv
// Shared definitions for the modulator symbol sequencer.
// Contents:
//   MOD_*          modulation codes used by the downstream mux
//   PHASE_W        width of the carrier phase index
//   state_t        sequencer FSM states
//   bits_per_sym   data bits consumed per symbol for a modulation code
//   presc_limit    terminal prescaler count for a frequency code
package modulator_symbol_sequencer_pkg;

   localparam int PHASE_W = 6;

   localparam logic [1:0] MOD_FSK  = 2'd0;
   localparam logic [1:0] MOD_ASK  = 2'd1;
   localparam logic [1:0] MOD_BPSK = 2'd2;
   localparam logic [1:0] MOD_QPSK = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   // QPSK packs two data bits into one symbol; every other scheme uses one.
   function automatic logic [1:0] bits_per_sym(input logic [1:0] m);
      return (m == MOD_QPSK) ? 2'd2 : 2'd1;
   endfunction

   // Phase advances once every 2^freq clocks, so the prescaler wraps at 2^freq-1.
   function automatic logic [2:0] presc_limit(input logic [1:0] f);
      logic [2:0] lim;
      case (f)
         2'd0:    lim = 3'd0;
         2'd1:    lim = 3'd1;
         2'd2:    lim = 3'd3;
         default: lim = 3'd7;
      endcase
      return lim;
   endfunction

endpackage

// File: rtl/modulator_symbol_sequencer_phase.sv
// Carrier phase generator: prescaler plus 6-bit phase counter.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   run        counting enable; when low the prescaler and phase sit at 0
//   freq       frequency code, phase advances every 2^freq clocks
//   phase      carrier phase index t (wraps 63 -> 0)
//   step       one-clock strobe: phase advances on this clock edge
//   wrap       phase is on its last step (63) of the carrier period
module phase_step_gen
   import modulator_symbol_sequencer_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic [1:0]         freq,
   output logic [PHASE_W-1:0] phase,
   output logic               step,
   output logic               wrap
);

   logic [2:0] prescaler;

   assign step = run && (prescaler == presc_limit(freq));
   assign wrap = (phase == {PHASE_W{1'b1}});

   // Holding run low parks both counters at zero, so every symbol that
   // follows a LOAD starts from phase 0 with a fresh prescaler. Between
   // back-to-back symbols run stays high and phase rolls 63->0 naturally.
   always_ff @(posedge clk) begin
      if (rst || !run) begin
         prescaler <= 3'd0;
         phase     <= '0;
      end else if (step) begin
         prescaler <= 3'd0;
         phase     <= phase + 1'b1;
      end else begin
         prescaler <= prescaler + 3'd1;
      end
   end

endmodule

// File: rtl/modulator_symbol_sequencer.sv
// Front-end sequencer for the FSK/ASK/BPSK/QPSK modulator.
// Collects serial data bits and configuration over valid/ready handshakes,
// holds each symbol for PERIODS_PER_SYM carrier periods and only applies
// mod/freq changes while idle so the carrier never glitches mid-cycle.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   bit_in/valid/ready    serial data handshake
//   cfg_mod/freq/valid    configuration request; cfg_ready high only in IDLE
//   sym                   current symbol ({first,second} for QPSK, sym[0] otherwise)
//   mod, freq             active configuration
//   phase                 carrier phase index to the sine generator
//   sym_start             pulse on the first phase step of each symbol
//   underrun              sticky: a symbol boundary found no data
module modulator_symbol_sequencer
   import modulator_symbol_sequencer_pkg::*;
#(
   parameter int PERIODS_PER_SYM = 1,
   parameter int CFG_RESET_MOD   = 2,
   parameter int CFG_RESET_FREQ  = 0
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               bit_in,
   input  logic               bit_valid,
   output logic               bit_ready,
   input  logic [1:0]         cfg_mod,
   input  logic [1:0]         cfg_freq,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   output logic [1:0]         sym,
   output logic [1:0]         mod,
   output logic [1:0]         freq,
   output logic [PHASE_W-1:0] phase,
   output logic               sym_start,
   output logic               underrun
);

   localparam logic [3:0] LAST_PERIOD = 4'(PERIODS_PER_SYM - 1);

   state_t     state;
   logic [1:0] hold_bits;
   logic [1:0] hold_cnt;
   logic [3:0] period_cnt;

   logic       run;
   logic       step;
   logic       wrap;
   logic       bit_fire;
   logic       cfg_fire;
   logic [1:0] eff_mod;
   logic [1:0] cnt_acc;
   logic [1:0] hold_acc;
   logic       full;
   logic       sym_done;
   logic [1:0] next_sym;

   assign run = (state == ST_RUN);

   phase_step_gen u_phase (
      .clk   (clk),
      .rst   (rst),
      .run   (run),
      .freq  (freq),
      .phase (phase),
      .step  (step),
      .wrap  (wrap)
   );

   // Bit buffer view after this clock's handshake. A cfg taken in the same
   // cycle already decides how many bits make a symbol, and cfg_ready is
   // never high outside IDLE so eff_mod equals mod in LOAD/RUN. Bits shift
   // in from the right so the first QPSK bit ends up in sym[1].
   always_comb begin
      bit_fire = bit_valid && bit_ready;
      cfg_fire = cfg_valid && cfg_ready;
      eff_mod  = cfg_fire ? cfg_mod : mod;
      cnt_acc  = hold_cnt + {1'b0, bit_fire};
      hold_acc = bit_fire ? {hold_bits[0], bit_in} : hold_bits;
      full     = (cnt_acc >= bits_per_sym(eff_mod));
      sym_done = step && wrap && (period_cnt == LAST_PERIOD);
      next_sym = (eff_mod == MOD_QPSK) ? hold_acc : {1'b0, hold_acc[0]};
   end

   // Main sequencer. Handshake readies are registered and recomputed from
   // the state being entered, so they drop the clock the buffer fills and
   // rise again the clock a symbol frees it. At a symbol boundary the
   // double-buffered next symbol is swapped in with no gap; otherwise the
   // stream drains to IDLE, keeping any half-collected QPSK pair.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         bit_ready  <= 1'b0;
         cfg_ready  <= 1'b0;
         sym        <= 2'd0;
         mod        <= 2'(CFG_RESET_MOD);
         freq       <= 2'(CFG_RESET_FREQ);
         sym_start  <= 1'b0;
         underrun   <= 1'b0;
         hold_bits  <= 2'd0;
         hold_cnt   <= 2'd0;
         period_cnt <= 4'd0;
      end else begin
         sym_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cfg_fire) begin
                  mod  <= cfg_mod;
                  freq <= cfg_freq;
               end
               hold_bits <= hold_acc;
               hold_cnt  <= cnt_acc;
               if (full) begin
                  state     <= ST_LOAD;
                  bit_ready <= 1'b0;
                  cfg_ready <= 1'b0;
               end else begin
                  bit_ready <= 1'b1;
                  cfg_ready <= 1'b1;
               end
            end
            ST_LOAD: begin
               sym        <= next_sym;
               hold_cnt   <= 2'd0;
               sym_start  <= 1'b1;
               period_cnt <= 4'd0;
               bit_ready  <= 1'b1;
               state      <= ST_RUN;
            end
            ST_RUN: begin
               if (sym_done) begin
                  period_cnt <= 4'd0;
                  if (full) begin
                     sym       <= next_sym;
                     hold_cnt  <= 2'd0;
                     sym_start <= 1'b1;
                     bit_ready <= 1'b1;
                  end else begin
                     underrun  <= 1'b1;
                     sym       <= 2'd0;
                     hold_bits <= hold_acc;
                     hold_cnt  <= cnt_acc;
                     bit_ready <= 1'b1;
                     cfg_ready <= 1'b1;
                     state     <= ST_IDLE;
                  end
               end else begin
                  if (step && wrap) begin
                     period_cnt <= period_cnt + 4'd1;
                  end
                  hold_bits <= hold_acc;
                  hold_cnt  <= cnt_acc;
                  bit_ready <= !full;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_modulator_symbol_sequencer.sv
// Scoreboard bench for modulator_symbol_sequencer: expected symbols are
// queued as data is issued and a monitor checks each sym_start against them.
module tb_modulator_symbol_sequencer;
   import modulator_symbol_sequencer_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bit_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       bit_ready;
   logic [1:0] cfg_mod = 2'd0;
   logic [1:0] cfg_freq = 2'd0;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   logic [1:0] sym;
   logic [1:0] mod;
   logic [1:0] freq;
   logic [5:0] phase;
   logic       sym_start;
   logic       underrun;

   typedef struct {
      logic [1:0] sym;
      logic [1:0] mod;
      logic [1:0] freq;
      int         gap;
   } exp_t;

   exp_t expQ[$];
   int   passCount = 0;
   int   checkCount = 0;
   int   cycle = 0;

   modulator_symbol_sequencer #(
      .PERIODS_PER_SYM (1),
      .CFG_RESET_MOD   (2),
      .CFG_RESET_FREQ  (0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .bit_ready (bit_ready),
      .cfg_mod   (cfg_mod),
      .cfg_freq  (cfg_freq),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .sym       (sym),
      .mod       (mod),
      .freq      (freq),
      .phase     (phase),
      .sym_start (sym_start),
      .underrun  (underrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Safety net so a stuck DUT cannot hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before 200000 ns");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   task automatic failTimeout(input string name);
      checkCount++;
      $display("[TB] FAIL %s: got timeout, expected handshake", name);
   endtask

   task automatic pushExp(input logic [1:0] s, input logic [1:0] m, input logic [1:0] f, input int g);
      exp_t e;
      e.sym = s;
      e.mod = m;
      e.freq = f;
      e.gap = g;
      expQ.push_back(e);
   endtask

   // Sends one data bit; caller is always #1 after a rising edge.
   task automatic applyStimulus(input logic b);
      int n;
      n = 0;
      bit_in = b;
      bit_valid = 1'b1;
      while (!bit_ready && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!bit_ready) failTimeout("bit_handshake");
      else begin
         @(posedge clk);
         #1;
      end
      bit_valid = 1'b0;
   endtask

   task automatic applyConfig(input logic [1:0] m, input logic [1:0] f);
      int n;
      n = 0;
      cfg_mod = m;
      cfg_freq = f;
      cfg_valid = 1'b1;
      while (!cfg_ready && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!cfg_ready) failTimeout("cfg_handshake");
      else begin
         @(posedge clk);
         #1;
      end
      cfg_valid = 1'b0;
   endtask

   task automatic waitIdle(input string name, input int limit);
      int n;
      n = 0;
      while (!cfg_ready && n < limit) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!cfg_ready) failTimeout(name);
   endtask

   task automatic doReset();
      bit_valid = 1'b0;
      cfg_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Monitor: every sym_start pops one expected symbol; for back-to-back
   // symbols it also checks spacing and that phase came from 63.
   initial begin
      exp_t e;
      int   lastStart;
      int   prevPhase;
      lastStart = -1;
      prevPhase = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            lastStart = -1;
         end else if (sym_start) begin
            if (expQ.size() == 0) begin
               checkCount++;
               $display("[TB] FAIL sb_unexpected: got symbol %0d, expected no symbol", sym);
            end else begin
               e = expQ.pop_front();
               checkOutput("sb_sym", sym, e.sym);
               checkOutput("sb_mod", mod, e.mod);
               checkOutput("sb_freq", freq, e.freq);
               checkOutput("sb_start_phase", phase, 0);
               if (e.gap != 0) begin
                  checkOutput("sb_gap", cycle - lastStart, e.gap);
                  checkOutput("sb_wrap_phase", prevPhase, 63);
               end
            end
            lastStart = cycle;
         end
         prevPhase = phase;
      end
   end

   initial begin
      int c0;

      // Reset defaults
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rst_mod", mod, MOD_BPSK);
      checkOutput("rst_freq", freq, 0);
      checkOutput("rst_phase", phase, 0);
      checkOutput("rst_underrun", underrun, 0);
      checkOutput("rst_sym", sym, 0);
      checkOutput("rst_cfg_ready", cfg_ready, 0);
      checkOutput("rst_bit_ready", bit_ready, 0);
      @(posedge clk);
      #1;
      checkOutput("idle_cfg_ready", cfg_ready, 1);
      checkOutput("idle_bit_ready", bit_ready, 1);

      // BPSK stream 1,0,1 back to back
      pushExp(2'd1, MOD_BPSK, 2'd0, 0);
      pushExp(2'd0, MOD_BPSK, 2'd0, 64);
      pushExp(2'd1, MOD_BPSK, 2'd0, 64);
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      applyStimulus(1'b1);
      checkOutput("bpsk_no_underrun", underrun, 0);
      waitIdle("bpsk_drain", 400);
      checkOutput("bpsk_end_underrun", underrun, 1);
      checkOutput("bpsk_end_phase", phase, 0);
      checkOutput("bpsk_end_sym", sym, 0);
      checkOutput("bpsk_sb_empty", expQ.size(), 0);

      // QPSK pairs 10 then 11
      applyConfig(MOD_QPSK, 2'd0);
      checkOutput("qpsk_mod", mod, MOD_QPSK);
      pushExp(2'b10, MOD_QPSK, 2'd0, 0);
      pushExp(2'b11, MOD_QPSK, 2'd0, 64);
      applyStimulus(1'b1);
      checkOutput("qpsk_half_pair_idle", cfg_ready, 1);
      applyStimulus(1'b0);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      waitIdle("qpsk_drain", 400);
      checkOutput("underrun_sticky", underrun, 1);
      checkOutput("qpsk_sb_empty", expQ.size(), 0);

      // Freq=2 timing, with a cfg request held off during RUN
      doReset();
      checkOutput("reset_clears_underrun", underrun, 0);
      applyConfig(MOD_BPSK, 2'd2);
      checkOutput("f2_freq", freq, 2);
      pushExp(2'd1, MOD_BPSK, 2'd2, 0);
      applyStimulus(1'b1);
      c0 = cycle;
      @(posedge clk);
      #1;
      checkOutput("latency_sym", sym, 1);
      checkOutput("f2_phase_start", phase, 0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("f2_phase_hold", phase, 0);
      @(posedge clk);
      #1;
      checkOutput("f2_phase_step1", phase, 1);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("f2_phase_step2", phase, 2);
      cfg_mod = MOD_ASK;
      cfg_freq = 2'd0;
      cfg_valid = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("cfg_blocked_ready", cfg_ready, 0);
      checkOutput("cfg_blocked_mod", mod, MOD_BPSK);
      waitIdle("f2_drain", 400);
      checkOutput("f2_sym_len", cycle - c0, 257);
      checkOutput("f2_underrun", underrun, 1);
      checkOutput("cfg_still_old", mod, MOD_BPSK);
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      checkOutput("cfg_taken_mod", mod, MOD_ASK);
      checkOutput("cfg_taken_freq", freq, 0);
      checkOutput("f2_sb_empty", expQ.size(), 0);

      // Reset mid-symbol drops a half-collected QPSK pair
      applyConfig(MOD_QPSK, 2'd0);
      pushExp(2'b10, MOD_QPSK, 2'd0, 0);
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      applyStimulus(1'b1);
      begin
         int n;
         n = 0;
         while (phase != 6'd30 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
         end
         if (phase != 6'd30) failTimeout("reach_phase30");
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midrst_phase", phase, 0);
      checkOutput("midrst_sym", sym, 0);
      checkOutput("midrst_bit_ready", bit_ready, 0);
      checkOutput("midrst_mod", mod, MOD_BPSK);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("midrst_idle", cfg_ready, 1);
      applyConfig(MOD_QPSK, 2'd0);
      pushExp(2'b01, MOD_QPSK, 2'd0, 0);
      applyStimulus(1'b0);
      applyStimulus(1'b1);
      waitIdle("midrst_drain", 400);
      checkOutput("midrst_sb_empty", expQ.size(), 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
